// File: rtl/uart_tx_frame_pkg.sv
// Shared constants for the UART transmit path.
// FSM encoding, parity selection and line levels.
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator for UART frames.
// Shared by the TX framer and the RX parity checker.
module uart_tx_parity_calc
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_par_bit
);

  assign o_par_bit = (^i_data) ^ (i_par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop.
// One clock per bit; outputs registered from the next state.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_p_data,
  input  logic                  i_data_valid,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  w_par_bit;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;
  logic                  r_tx;
  logic                  r_busy;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_par (
    .i_data   (r_data),
    .i_par_typ(r_par_typ),
    .o_par_bit(w_par_bit)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == IDLE && i_data_valid) begin
        r_data    <= i_p_data;
        r_par_en  <= i_par_en;
        r_par_typ <= i_par_typ;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (i_data_valid) w_state_nxt = START;
      end
      START: begin
        w_state_nxt = DATA;
        w_cnt_nxt   = '0;
      end
      DATA: begin
        if (r_cnt == LAST) begin
          w_state_nxt = r_par_en ? PARITY : STOP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      PARITY: w_state_nxt = STOP;
      STOP:   w_state_nxt = IDLE;
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Decoding the next state lets busy drop in the first idle cycle.
  always_comb begin
    w_tx_nxt   = LINE_IDLE;
    w_busy_nxt = 1'b1;
    unique case (w_state_nxt)
      IDLE:    w_busy_nxt = 1'b0;
      START:   w_tx_nxt   = START_BIT;
      DATA:    w_tx_nxt   = r_data[w_cnt_nxt];
      PARITY:  w_tx_nxt   = w_par_bit;
      STOP:    w_tx_nxt   = LINE_IDLE;
      default: w_busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tx   <= LINE_IDLE;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign o_tx_out = r_tx;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame.
// Model pushes expected line bits; monitor pops one per cycle.
module tb_uart_tx_frame;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          valid;
  logic          par_en;
  logic          par_typ;
  logic          tx;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic tx;
    logic busy;
  } exp_t;

  exp_t sb[$];

  uart_tx_frame #(
    .DATA_WIDTH(DW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_p_data    (p_data),
    .i_data_valid(valid),
    .i_par_en    (par_en),
    .i_par_typ   (par_typ),
    .o_tx_out    (tx),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%0b exp=%0b t=%0t", n, a, e, $time);
    end
  endtask

  // Frame: start, data LSB first, optional parity, stop, then one idle bit.
  function automatic void push_frame(logic [DW-1:0] d, logic en,
                                     logic typ);
    sb.push_back(exp_t'{tx: 1'b0, busy: 1'b1});
    for (int i = 0; i < DW; i++)
      sb.push_back(exp_t'{tx: d[i], busy: 1'b1});
    if (en)
      sb.push_back(exp_t'{tx: 1'($countones(d) % 2) ^ typ, busy: 1'b1});
    sb.push_back(exp_t'{tx: 1'b1, busy: 1'b1});
    sb.push_back(exp_t'{tx: 1'b1, busy: 1'b0});
  endfunction

  // Reference: an offer is taken only once the previous frame has drained.
  always @(posedge clk) begin
    if (rst && valid && sb.size() == 0)
      push_frame(p_data, par_en, par_typ);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("line_tx", tx, e.tx);
      chk("line_busy", busy, e.busy);
    end else begin
      chk("idle_tx", tx, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end
  end

  task automatic offer(input logic [DW-1:0] d, input logic en,
                       input logic typ);
    @(negedge clk);
    p_data  = d;
    par_en  = en;
    par_typ = typ;
    valid   = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b0;
    valid   = 1'b0;
    p_data  = '0;
    par_en  = 1'b0;
    par_typ = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);

    // Abandon a frame during data bit 3; the line must rise at once.
    offer(8'hA5, 1'b0, 1'b0);
    idle(4);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    sb.delete();
    idle(2);
    rst = 1'b1;
    idle(5);

    offer(8'hA5, 1'b0, 1'b0);
    idle(12);
    offer(8'hA5, 1'b1, 1'b0);
    idle(13);
    offer(8'hA5, 1'b1, 1'b1);
    idle(13);
    offer(8'h00, 1'b1, 1'b1);
    idle(13);

    // Valid held high: two frames, the second taking the updated byte.
    @(negedge clk);
    p_data = 8'h3C;
    par_en = 1'b0;
    valid  = 1'b1;
    idle(4);
    p_data = 8'hFF;
    idle(18);
    valid = 1'b0;
    idle(12);

    // An offer while busy is dropped.
    offer(8'h5A, 1'b0, 1'b0);
    idle(3);
    offer(8'h12, 1'b1, 1'b1);
    idle(12);

    for (int k = 0; k < 40; k++) begin
      offer(8'($urandom), 1'($urandom), 1'($urandom));
      idle($urandom_range(0, 14));
    end

    for (int w = 0; w < 40 && sb.size() > 0; w++) @(negedge clk);
    chk("drain_empty", 1'(sb.size() == 0), 1'b1);
    idle(2);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
